// File: rtl/gcd_job_arbiter.sv
// gcd_job_arbiter: round-robin sharing of one GCD/Bezout core among NUM_REQ requesters.
// Latches the winner's operands, pulses start, waits for done under a watchdog, returns tagged results.
module gcd_job_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2,
   parameter int TIMEOUT = 4000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [3*NUM_REQ-1:0]    req_op_code,
   input  logic [1279*NUM_REQ-1:0] req_a,
   input  logic [1279*NUM_REQ-1:0] req_b,
   input  logic [NUM_REQ-1:0]      req_ct,
   output logic                    core_start,
   output logic [2:0]              core_op_code,
   output logic [1278:0]           core_a,
   output logic [1278:0]           core_b,
   output logic                    core_constant_time,
   input  logic                    core_done,
   input  logic [11:0]             core_cycle_count,
   input  logic [1283:0]           core_bezout_a,
   input  logic [1283:0]           core_bezout_b,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic                    rsp_err,
   output logic [11:0]             rsp_cycles,
   output logic [1283:0]           rsp_bezout_a,
   output logic [1283:0]           rsp_bezout_b,
   output logic                    busy
);
   localparam int AW = 1279;
   localparam int RW = 1284;
   localparam logic [11:0] WD_LAST = 12'(TIMEOUT - 1);
   typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;
   state_t          state_q, state_d;
   logic [ID_W-1:0] ptr_q, ptr_d, id_q, id_d, gnt, idx;
   logic [2:0]      op_q, op_d;
   logic [AW-1:0]   a_q, a_d, b_q, b_d;
   logic            ct_q, ct_d, err_q, err_d, done_q, found, rise;
   logic [RW-1:0]   ba_q, ba_d, bb_q, bb_d;
   logic [11:0]     cyc_q, cyc_d, wd_q, wd_d;
   assign rise = core_done & ~done_q;
   // First valid requester after the last winner, wrapping around.
   always_comb begin
      gnt = ptr_q;
      idx = ptr_q;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            gnt = idx;
         end
      end
   end
   always_comb begin
      state_d = state_q;
      ptr_d = ptr_q;
      id_d = id_q;
      op_d = op_q;
      a_d = a_q;
      b_d = b_q;
      ct_d = ct_q;
      ba_d = ba_q;
      bb_d = bb_q;
      cyc_d = cyc_q;
      err_d = err_q;
      wd_d = wd_q;
      req_ready = '0;
      unique case (state_q)
         IDLE: if (found) begin
            req_ready[gnt] = 1'b1;
            ptr_d = gnt;
            id_d = gnt;
            op_d = req_op_code[int'(gnt)*3 +: 3];
            a_d = req_a[int'(gnt)*AW +: AW];
            b_d = req_b[int'(gnt)*AW +: AW];
            ct_d = req_ct[gnt];
            state_d = ISSUE;
         end
         ISSUE: begin
            wd_d = '0;
            state_d = BUSY;
         end
         BUSY: if (rise) begin
            ba_d = core_bezout_a;
            bb_d = core_bezout_b;
            cyc_d = core_cycle_count;
            err_d = 1'b0;
            state_d = RESP;
         end else if (wd_q == WD_LAST) begin
            ba_d = '0;
            bb_d = '0;
            cyc_d = '0;
            err_d = 1'b1;
            state_d = RESP;
         end else begin
            wd_d = wd_q + 12'd1;
         end
         RESP: state_d = rsp_ready ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q <= ID_W'(NUM_REQ - 1);
         id_q <= '0;
         op_q <= '0;
         a_q <= '0;
         b_q <= '0;
         ct_q <= 1'b0;
         ba_q <= '0;
         bb_q <= '0;
         cyc_q <= '0;
         err_q <= 1'b0;
         wd_q <= '0;
         done_q <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         id_q <= id_d;
         op_q <= op_d;
         a_q <= a_d;
         b_q <= b_d;
         ct_q <= ct_d;
         ba_q <= ba_d;
         bb_q <= bb_d;
         cyc_q <= cyc_d;
         err_q <= err_d;
         wd_q <= wd_d;
         done_q <= core_done;
      end
   end
   assign core_start = state_q == ISSUE;
   assign rsp_valid = state_q == RESP;
   assign busy = state_q != IDLE;
   assign core_op_code = op_q;
   assign core_a = a_q;
   assign core_b = b_q;
   assign core_constant_time = ct_q;
   assign rsp_id = id_q;
   assign rsp_err = err_q;
   assign rsp_cycles = cyc_q;
   assign rsp_bezout_a = ba_q;
   assign rsp_bezout_b = bb_q;
endmodule
